// File: rtl/game_outcome_judge.sv
// Per-level referee: countdown timer plus goal/hazard persistence filters, one verdict pulse per session.
// Define JUDGE_TIMEOUT_EN to enable the per-second countdown and timeout loss.
//
// state     | meaning
// S_IDLE    | not playing; counters held at 0, waits for game_state == 2
// S_ARMED   | session running; counters advance on frame_tick
// S_DECIDED | verdict issued; everything frozen until game_state leaves 2
module game_outcome_judge #(
   parameter int FRAMES_PER_SEC = 60,
   parameter int LEVEL0_SECONDS = 90,
   parameter int LEVEL1_SECONDS = 120,
   parameter int HAZARD_FRAMES  = 2,
   parameter int GOAL_FRAMES    = 1
) (
   input  logic       pixel_clk,
   input  logic       reset,
   input  logic [3:0] game_state,
   input  logic [1:0] selector_value,
   input  logic       frame_tick,
   input  logic       goal_hit,
   input  logic       hazard_hit,
   output logic       win_the_game,
   output logic       lose_the_game,
   output logic [7:0] time_left
);

   localparam logic [3:0] GOAL_TH = 4'(GOAL_FRAMES);
   localparam logic [3:0] HAZ_TH  = 4'(HAZARD_FRAMES);
   localparam logic [7:0] LIMIT0  = 8'(LEVEL0_SECONDS);
   localparam logic [7:0] LIMIT1  = 8'(LEVEL1_SECONDS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_DECIDED
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] goal_q, goal_d;
   logic [3:0] haz_q, haz_d;
   logic [7:0] time_q, time_d;
   logic       win_q, win_d;
   logic       lose_q, lose_d;
   logic [3:0] goal_nxt;
   logic [3:0] haz_nxt;
   logic       timeout_hit;
   logic       playing;

`ifdef JUDGE_TIMEOUT_EN
   localparam int              FW         = $clog2(FRAMES_PER_SEC);
   localparam logic [FW-1:0]   FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
   logic [FW-1:0] frame_q, frame_d;
`endif

   assign playing = (game_state == 4'd2);

   always_comb begin
      state_d     = state_q;
      goal_d      = goal_q;
      haz_d       = haz_q;
      time_d      = time_q;
      win_d       = 1'b0;
      lose_d      = 1'b0;
      goal_nxt    = goal_q;
      haz_nxt     = haz_q;
      timeout_hit = 1'b0;
`ifdef JUDGE_TIMEOUT_EN
      frame_d     = frame_q;
`endif
      case (state_q)
         S_IDLE: begin
            goal_d = 4'd0;
            haz_d  = 4'd0;
`ifdef JUDGE_TIMEOUT_EN
            frame_d = '0;
`endif
            if (playing) begin
               state_d = S_ARMED;
               time_d  = (selector_value == 2'd0) ? LIMIT0 : LIMIT1;
            end
         end
         S_ARMED: begin
            if (!playing) begin
               state_d = S_IDLE;
            end else if (frame_tick) begin
               // Filters saturate at threshold; a miss restarts the run.
               if (!goal_hit)             goal_nxt = 4'd0;
               else if (goal_q < GOAL_TH) goal_nxt = goal_q + 4'd1;
               if (!hazard_hit)           haz_nxt = 4'd0;
               else if (haz_q < HAZ_TH)   haz_nxt = haz_q + 4'd1;
               goal_d = goal_nxt;
               haz_d  = haz_nxt;
`ifdef JUDGE_TIMEOUT_EN
               if (frame_q == FRAME_LAST) begin
                  frame_d = '0;
                  if (time_q != 8'd0) begin
                     time_d      = time_q - 8'd1;
                     timeout_hit = (time_q == 8'd1);
                  end
               end else begin
                  frame_d = frame_q + 1'b1;
               end
`endif
               // Win has priority over any loss raised on the same tick.
               if (goal_nxt >= GOAL_TH) begin
                  win_d   = 1'b1;
                  state_d = S_DECIDED;
               end else if ((haz_nxt >= HAZ_TH) || timeout_hit) begin
                  lose_d  = 1'b1;
                  state_d = S_DECIDED;
               end
            end
         end
         S_DECIDED: begin
            if (!playing) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         goal_q  <= 4'd0;
         haz_q   <= 4'd0;
         time_q  <= 8'd0;
         win_q   <= 1'b0;
         lose_q  <= 1'b0;
`ifdef JUDGE_TIMEOUT_EN
         frame_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         goal_q  <= goal_d;
         haz_q   <= haz_d;
         time_q  <= time_d;
         win_q   <= win_d;
         lose_q  <= lose_d;
`ifdef JUDGE_TIMEOUT_EN
         frame_q <= frame_d;
`endif
      end
   end

   assign win_the_game  = win_q;
   assign lose_the_game = lose_q;
   assign time_left     = time_q;

endmodule

// File: tb/tb_game_outcome_judge.sv
// Scoreboard bench for game_outcome_judge: directed sessions push expected verdicts,
// a monitor pops them whenever a pulse appears.
module tb_game_outcome_judge;

   logic       pixel_clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] game_state = 4'd0;
   logic [1:0] selector_value = 2'd0;
   logic       frame_tick = 1'b0;
   logic       goal_hit = 1'b0;
   logic       hazard_hit = 1'b0;
   logic       win_the_game;
   logic       lose_the_game;
   logic [7:0] time_left;

`ifdef JUDGE_TIMEOUT_EN
   localparam int TO = 1;
`else
   localparam int TO = 0;
`endif

   typedef struct packed {
      logic       w;
      logic       l;
      logic [7:0] t;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   game_outcome_judge #(
      .FRAMES_PER_SEC(4),
      .LEVEL0_SECONDS(3),
      .LEVEL1_SECONDS(5),
      .HAZARD_FRAMES(2),
      .GOAL_FRAMES(1)
   ) dut (
      .pixel_clk     (pixel_clk),
      .reset         (reset),
      .game_state    (game_state),
      .selector_value(selector_value),
      .frame_tick    (frame_tick),
      .goal_hit      (goal_hit),
      .hazard_hit    (hazard_hit),
      .win_the_game  (win_the_game),
      .lose_the_game (lose_the_game),
      .time_left     (time_left)
   );

   always #5 pixel_clk = ~pixel_clk;

   task automatic check(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, want);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge pixel_clk);
         #1;
      end
   endtask

   task automatic tick(input logic g, input logic h);
      frame_tick = 1'b1;
      goal_hit   = g;
      hazard_hit = h;
      cyc(1);
      frame_tick = 1'b0;
      goal_hit   = 1'b0;
      hazard_hit = 1'b0;
   endtask

   task automatic enter(input logic [1:0] sel, input string name, input int limit);
      selector_value = sel;
      game_state     = 4'd2;
      cyc(1);
      check(name, time_left, limit);
   endtask

   task automatic leave();
      game_state = 4'd1;
      cyc(2);
   endtask

   task automatic push(input logic w, input logic l, input int t);
      exp_t e;
      e.w = w;
      e.l = l;
      e.t = 8'(t);
      exp_q.push_back(e);
   endtask

   task automatic drained(input string name);
      cyc(3);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      fork
         forever begin : monitor
            exp_t e;
            @(negedge pixel_clk);
            if (win_the_game || lose_the_game) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", {win_the_game, lose_the_game}, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("verdict", {win_the_game, lose_the_game, time_left}, {e.w, e.l, e.t});
               end
            end
         end
      join_none

      cyc(3);
      reset = 1'b0;
      check("reset_win", win_the_game, 0);
      check("reset_lose", lose_the_game, 0);
      check("reset_time", time_left, 0);
      cyc(2);

`ifdef JUDGE_TIMEOUT_EN
      enter(2'd0, "to_entry", 3);
      for (int i = 1; i <= 12; i++) begin
         if (i == 12) push(1'b0, 1'b1, 0);
         tick(1'b0, 1'b0);
         if (i == 4) check("to_time_t4", time_left, 2);
         if (i == 8) check("to_time_t8", time_left, 1);
      end
      check("to_time_t12", time_left, 0);
      drained("to_drain");
      leave();
`else
      enter(2'd0, "hold_entry", 3);
      for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
      check("hold_time", time_left, 3);
      drained("hold_drain");
      leave();
`endif

      // Hazard filter; the hazard tick during the entry cycle must not count.
      selector_value = 2'd0;
      game_state     = 4'd2;
      frame_tick     = 1'b1;
      hazard_hit     = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      hazard_hit = 1'b0;
      check("haz_entry_time", time_left, 3);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      push(1'b0, 1'b1, TO ? 2 : 3);
      tick(1'b0, 1'b1);
      drained("haz_drain");
      leave();

      // Goal and hazard thresholds met on the same tick: win only.
      enter(2'd0, "sim_entry", 3);
      tick(1'b0, 1'b1);
      push(1'b1, 1'b0, 3);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      drained("sim_drain");
      leave();

      // Level 1 sessions reload the full limit each time.
      enter(2'd1, "lvl1_first", 5);
      leave();
      enter(2'd1, "lvl1_second", 5);
      tick(1'b0, 1'b1);
      push(1'b0, 1'b1, 5);
      tick(1'b0, 1'b1);
      drained("lvl1_drain");
      leave();
      enter(2'd1, "lvl1_after_loss", 5);
      leave();

      // Leaving play mid-session: no verdict even with a deciding tick pending.
      enter(2'd0, "exit_entry", 3);
      tick(1'b0, 1'b1);
      game_state = 4'd0;
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      drained("exit_drain");

      // Reset with hazard counter at 1 and a deciding tick in the same cycle.
      enter(2'd0, "rst_entry", 3);
      tick(1'b0, 1'b1);
      reset = 1'b1;
      tick(1'b0, 1'b1);
      check("rst_win", win_the_game, 0);
      check("rst_lose", lose_the_game, 0);
      check("rst_time", time_left, 0);
      reset = 1'b0;
      drained("rst_drain");
      game_state = 4'd0;
      cyc(2);
      enter(2'd0, "post_rst_entry", 3);
      leave();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
